// File: rtl/mem_responder.sv
// Word-organized data memory slave for an RV32I core: multi-cycle handshake with
// programmable wait states, byte-lane stores, sign/zero-extended sub-word loads.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] byte_addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mrd_i,
    input  logic                  mwr_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  busy_o,
    output logic                  rdy_o,
    output logic                  err_o
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   addr_reg, wd_reg, rd_reg, rdata_reg, load_value;
    logic [2:0]              f3_reg;
    logic                    wr_reg, req_err_reg, err_reg;
    logic                    accept, mem_we;
    logic [AW-1:0]           ridx, widx;
    logic [NB-1:0]           be;
    logic [NB-1:0][7:0]      wlane;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // All protocol and range errors are decided once, from the request as accepted.
    function automatic logic req_error(input logic [DATA_WIDTH-1:0] a, input logic [2:0] f,
                                       input logic r, input logic w);
        logic bad;
        bad = (r && w) || ({2'b00, a[DATA_WIDTH-1:2]} >= DATA_WIDTH'(DEPTH_WORDS));
        case (f)
            3'b000:  bad = bad;
            3'b001:  bad = bad || a[0];
            3'b010:  bad = bad || (a[1:0] != 2'b00);
            3'b100:  bad = bad || w;
            3'b101:  bad = bad || w || a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign accept = (state_reg == IDLE) && (mrd_i || mwr_i);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
                    cnt_next   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'(WAIT_STATES - 1)) begin
                    state_next = ACCESS;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ACCESS:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= '0;
            wd_reg      <= '0;
            f3_reg      <= 3'd0;
            wr_reg      <= 1'b0;
            req_err_reg <= 1'b0;
            rd_reg      <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg    <= byte_addr_i;
                wd_reg      <= wd_i;
                f3_reg      <= funct3_i;
                wr_reg      <= mwr_i;
                req_err_reg <= req_error(byte_addr_i, funct3_i, mrd_i, mwr_i);
            end
            if (state_reg == ACCESS) begin
                err_reg <= req_err_reg;
                if (!req_err_reg && !wr_reg)
                    rd_reg <= load_value;
            end else if (state_reg == DONE) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Byte-lane enables and lane data for stores; halfwords/bytes are replicated across lanes.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            always_comb begin
                be[gi]    = 1'b0;
                wlane[gi] = wd_reg[gi*8 +: 8];
                case (f3_reg)
                    3'b000: begin
                        be[gi]    = (addr_reg[1:0] == 2'(gi));
                        wlane[gi] = wd_reg[7:0];
                    end
                    3'b001: begin
                        be[gi]    = (addr_reg[1] == 1'(gi / 2));
                        wlane[gi] = wd_reg[(gi % 2)*8 +: 8];
                    end
                    3'b010:  be[gi] = 1'b1;
                    default: be[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // The read port is addressed from the bus while idle so the word is ready in ACCESS
    // even with zero wait states.
    assign ridx   = (state_reg == IDLE) ? byte_addr_i[AW+1:2] : addr_reg[AW+1:2];
    assign widx   = addr_reg[AW+1:2];
    assign mem_we = (state_reg == ACCESS) && wr_reg && !req_err_reg && reset_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++)
                if (be[b])
                    mem[widx][b*8 +: 8] <= wlane[b];
        end
        rdata_reg <= mem[ridx];
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] lane;
        lane = rdata_reg >> {addr_reg[1:0], 3'b000};
        case (f3_reg)
            3'b000:  load_value = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_value = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: load_value = rdata_reg;
        endcase
    end

    assign rd_o   = rd_reg;
    assign busy_o = (state_reg == WAIT) || (state_reg == ACCESS);
    assign rdy_o  = (state_reg == DONE);
    assign err_o  = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (1, 0 and 15 wait states) driven by
// one sequence; expected completions are queued at issue and popped on rdy_o.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] req_addr [3];
    logic [31:0] req_wd   [3];
    logic [2:0]  req_f3   [3];
    logic [2:0]  req_rd   = 3'b000;
    logic [2:0]  req_wr   = 3'b000;
    logic [31:0] rd_o     [3];
    logic [2:0]  busy_o, rdy_o, err_o;

    int checks   = 0;
    int failures = 0;
    int wst [3] = '{1, 0, 15};

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(1), .DEPTH_WORDS(1024)) dut0 (
        .clk_i(clk), .reset_i(reset_n), .byte_addr_i(req_addr[0]), .wd_i(req_wd[0]),
        .funct3_i(req_f3[0]), .mrd_i(req_rd[0]), .mwr_i(req_wr[0]),
        .rd_o(rd_o[0]), .busy_o(busy_o[0]), .rdy_o(rdy_o[0]), .err_o(err_o[0]));

    mem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(64)) dut1 (
        .clk_i(clk), .reset_i(reset_n), .byte_addr_i(req_addr[1]), .wd_i(req_wd[1]),
        .funct3_i(req_f3[1]), .mrd_i(req_rd[1]), .mwr_i(req_wr[1]),
        .rd_o(rd_o[1]), .busy_o(busy_o[1]), .rdy_o(rdy_o[1]), .err_o(err_o[1]));

    mem_responder #(.WAIT_STATES(15), .DEPTH_WORDS(64)) dut2 (
        .clk_i(clk), .reset_i(reset_n), .byte_addr_i(req_addr[2]), .wd_i(req_wd[2]),
        .funct3_i(req_f3[2]), .mrd_i(req_rd[2]), .mwr_i(req_wr[2]),
        .rd_o(rd_o[2]), .busy_o(busy_o[2]), .rdy_o(rdy_o[2]), .err_o(err_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request (inputs applied now, accepted at the next rising edge), then
    // follows it to completion. poke re-presents a read while busy and during DONE.
    task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input logic [2:0] f,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit poke, input string tag);
        exp_t e;
        int   k;
        int   nbusy;
        bit   seen;
        sb.push_back('{exp_rd, exp_err});
        req_addr[d] = a;
        req_wd[d]   = data;
        req_f3[d]   = f;
        req_rd[d]   = r;
        req_wr[d]   = w;
        @(posedge clk); #1;
        req_rd[d] = 1'b0;
        req_wr[d] = 1'b0;
        if (poke) req_rd[d] = 1'b1;
        k = 0; nbusy = 0; seen = 1'b0;
        while (1) begin
            if (rdy_o[d]) begin
                seen = 1'b1;
                break;
            end
            if (busy_o[d]) nbusy++;
            if (k >= 40) break;
            @(posedge clk); #1;
            k++;
            if (poke && k == 1) req_rd[d] = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, ".done"}, 32'(seen), 32'd1);
        chk({tag, ".rd"}, rd_o[d], e.rd);
        chk({tag, ".err"}, 32'(err_o[d]), 32'(e.err));
        chk({tag, ".latency"}, 32'(k), 32'(wst[d] + 1));
        chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(wst[d] + 1));
        $display("txn dut%0d %s addr=%h rd=%h err=%0d lat=%0d", d, tag, a, rd_o[d], err_o[d], k);
        if (poke) req_rd[d] = 1'b1;
        for (int i = 0; i < (poke ? 4 : 1); i++) begin
            @(posedge clk); #1;
            if (i == 0) req_rd[d] = 1'b0;
            chk({tag, ".rdy_single"}, 32'(rdy_o[d]), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = '0;
            req_wd[d]   = '0;
            req_f3[d]   = 3'b010;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset.rd", rd_o[d], 32'd0);
            chk("reset.busy", 32'(busy_o[d]), 32'd0);
            chk("reset.rdy", 32'(rdy_o[d]), 32'd0);
            chk("reset.err", 32'(err_o[d]), 32'd0);
        end
        reset_n = 1'b1;

        req(0, 0, 1, 32'h40, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0, "SW40");
        req(0, 1, 0, 32'h40, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0, "LW40");
        req(0, 0, 1, 32'h44, 32'h8001F07F, 3'b010, 32'hDEADBEEF, 0, 0, "SW44");
        req(0, 1, 0, 32'h44, 32'h0, 3'b000, 32'h0000007F, 0, 0, "LB44");
        req(0, 1, 0, 32'h45, 32'h0, 3'b000, 32'hFFFFFFF0, 0, 0, "LB45");
        req(0, 1, 0, 32'h45, 32'h0, 3'b100, 32'h000000F0, 0, 0, "LBU45");
        req(0, 1, 0, 32'h46, 32'h0, 3'b001, 32'hFFFF8001, 0, 0, "LH46");
        req(0, 1, 0, 32'h46, 32'h0, 3'b101, 32'h00008001, 0, 0, "LHU46");
        req(0, 0, 1, 32'h48, 32'h11223344, 3'b010, 32'h00008001, 0, 0, "SW48");
        req(0, 0, 1, 32'h49, 32'h000000AA, 3'b000, 32'h00008001, 0, 0, "SB49");
        req(0, 0, 1, 32'h4A, 32'h0000BBCC, 3'b001, 32'h00008001, 0, 0, "SH4A");
        req(0, 1, 0, 32'h48, 32'h0, 3'b010, 32'hBBCCAA44, 0, 0, "LW48");

        req(0, 1, 0, 32'h41, 32'h0, 3'b001, 32'hBBCCAA44, 1, 0, "ERR_LH41");
        req(0, 0, 1, 32'h4A, 32'h55555555, 3'b010, 32'hBBCCAA44, 1, 0, "ERR_SW4A");
        req(0, 1, 0, 32'h1000, 32'h0, 3'b010, 32'hBBCCAA44, 1, 0, "ERR_LWRANGE");
        req(0, 1, 1, 32'h40, 32'hFFFFFFFF, 3'b010, 32'hBBCCAA44, 1, 0, "ERR_BOTH");
        req(0, 1, 0, 32'h40, 32'h0, 3'b011, 32'hBBCCAA44, 1, 0, "ERR_LF3");
        req(0, 0, 1, 32'h40, 32'h01010101, 3'b100, 32'hBBCCAA44, 1, 0, "ERR_SF3");
        req(0, 1, 0, 32'h40, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0, "LW40_KEEP");
        req(0, 1, 0, 32'h48, 32'h0, 3'b010, 32'hBBCCAA44, 0, 0, "LW48_KEEP");

        req(0, 1, 0, 32'h44, 32'h0, 3'b010, 32'h8001F07F, 0, 1, "LW44_POKE");

        req(0, 0, 1, 32'h50, 32'hCAFEF00D, 3'b010, 32'h8001F07F, 0, 0, "SW50");
        req_addr[0] = 32'h50;
        req_wd[0]   = 32'h12345678;
        req_f3[0]   = 3'b010;
        req_wr[0]   = 1'b1;
        @(posedge clk); #1;
        req_wr[0] = 1'b0;
        chk("abort.in_wait", 32'(busy_o[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort.rd", rd_o[0], 32'd0);
        chk("abort.busy", 32'(busy_o[0]), 32'd0);
        chk("abort.rdy", 32'(rdy_o[0]), 32'd0);
        chk("abort.err", 32'(err_o[0]), 32'd0);
        $display("txn dut0 SW50_ABORT reset asserted in WAIT");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        req(0, 1, 0, 32'h50, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0, "LW50_OLD");

        req(1, 0, 1, 32'h10, 32'h0BADF00D, 3'b010, 32'h0, 0, 0, "W0_SW10");
        req(1, 1, 0, 32'h10, 32'h0, 3'b010, 32'h0BADF00D, 0, 0, "W0_LW10");
        req(2, 0, 1, 32'h10, 32'h0BADF00D, 3'b010, 32'h0, 0, 0, "W15_SW10");
        req(2, 1, 0, 32'h10, 32'h0, 3'b010, 32'h0BADF00D, 0, 0, "W15_LW10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
